ysyx_23060203_ifu_fetch: RTL and testbench



---
 rtl/ysyx_23060203_ifu_fetch.sv | 118 +++++++++++
 tb/tb_ysyx_23060203_ifu_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one single-beat read per
// instruction to the icache and presents the word to decode via a register slice.
module ysyx_23060203_ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h3000_0000,
   parameter int          PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rstn,
   output logic [31:0] ar_addr,
   output logic        ar_valid,
   input  logic        ar_ready,
   input  logic [63:0] r_data,
   input  logic [1:0]  r_resp,
   input  logic        r_valid,
   output logic        r_ready,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_fault,
   input  logic        redir_valid,
   input  logic [31:0] redir_pc
);

   typedef enum logic [1:0] {S_REQ, S_RESP, S_OUT} state_t;

   state_t      state, state_nx;
   logic        run;
   logic [31:0] pc, pc_nx;
   logic [31:0] pend_pc, pend_pc_nx;
   logic        flush, flush_nx;
   logic        inst_valid_nx;
   logic [31:0] inst_nx, inst_pc_nx;
   logic        inst_fault_nx;

   // run keeps the request off the bus during the first cycle out of reset
   assign ar_valid = run && (state == S_REQ);
   assign ar_addr  = pc;
   assign r_ready  = (state == S_RESP);

   always_comb begin
      state_nx      = state;
      pc_nx         = pc;
      pend_pc_nx    = pend_pc;
      flush_nx      = flush;
      inst_valid_nx = inst_valid;
      inst_nx       = inst;
      inst_pc_nx    = inst_pc;
      inst_fault_nx = inst_fault;
      case (state)
         S_REQ: begin
            // address must stay put on the bus, so park the target and squash
            if (redir_valid) begin
               pend_pc_nx = redir_pc;
               flush_nx   = 1'b1;
            end
            if (ar_valid && ar_ready) state_nx = S_RESP;
         end
         S_RESP: begin
            if (redir_valid) begin
               pend_pc_nx = redir_pc;
               flush_nx   = 1'b1;
            end
            if (r_valid) begin
               if (flush || redir_valid) begin
                  flush_nx = 1'b0;
                  pc_nx    = redir_valid ? redir_pc : pend_pc;
                  state_nx = S_REQ;
               end else begin
                  inst_nx       = pc[2] ? r_data[63:32] : r_data[31:0];
                  inst_pc_nx    = pc;
                  inst_fault_nx = (r_resp != 2'b00);
                  inst_valid_nx = 1'b1;
                  state_nx      = S_OUT;
               end
            end
         end
         S_OUT: begin
            // a redirect beats a same-cycle handshake: the held word is stale
            if (redir_valid) begin
               inst_valid_nx = 1'b0;
               pc_nx         = redir_pc;
               state_nx      = S_REQ;
            end else if (inst_ready) begin
               inst_valid_nx = 1'b0;
               pc_nx         = pc + 32'(PC_STEP);
               state_nx      = S_REQ;
            end
         end
         default: state_nx = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_REQ;
         run        <= 1'b0;
         pc         <= RESET_PC;
         pend_pc    <= RESET_PC;
         flush      <= 1'b0;
         inst_valid <= 1'b0;
         inst       <= 32'h0;
         inst_pc    <= 32'h0;
         inst_fault <= 1'b0;
      end else begin
         state      <= state_nx;
         run        <= 1'b1;
         pc         <= pc_nx;
         pend_pc    <= pend_pc_nx;
         flush      <= flush_nx;
         inst_valid <= inst_valid_nx;
         inst       <= inst_nx;
         inst_pc    <= inst_pc_nx;
         inst_fault <= inst_fault_nx;
      end
   end

endmodule

// File: tb/tb_ysyx_23060203_ifu_fetch.sv
// Bench for the fetch stage: directed scenarios, then randomized cache/decode/
// redirect traffic checked against a transaction-level model of the fetch stream.
module tb_ysyx_23060203_ifu_fetch;

   localparam logic [31:0] RESET_PC = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] ar_addr;
   logic        ar_valid;
   logic        ar_ready = 1'b0;
   logic [63:0] r_data = '0;
   logic [1:0]  r_resp = '0;
   logic        r_valid = 1'b0;
   logic        r_ready;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_fault;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_pc = '0;

   int checks = 0;
   int errors = 0;

   ysyx_23060203_ifu_fetch #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
      .clk(clk), .rstn(rstn),
      .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .inst_fault(inst_fault),
      .redir_valid(redir_valid), .redir_pc(redir_pc)
   );

   always #5 clk = ~clk;

   // model of the fetch stream
   logic [31:0] exp_addr;   // address the next request must carry
   logic [31:0] cur_addr;   // address of the outstanding / held fetch
   logic [31:0] tgt;        // latest redirect target not yet applied
   logic        outstanding, exp_iv, stale;
   logic [31:0] e_inst, e_pc;
   logic        e_flt;

   function automatic logic [31:0] word(input logic [31:0] a);
      case (a)
         32'h3000_0000: word = 32'h0010_0093;
         32'h3000_0004: word = 32'h0000_0013;
         default:       word = (a * 32'h9E37_79B1) ^ 32'h1234_5678;
      endcase
   endfunction

   function automatic logic [63:0] line(input logic [31:0] a);
      line = {word({a[31:3], 3'b100}), word({a[31:3], 3'b000})};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_addr    = RESET_PC;
      cur_addr    = RESET_PC;
      tgt         = RESET_PC;
      outstanding = 1'b0;
      exp_iv      = 1'b0;
      stale       = 1'b0;
   endtask

   // One clock cycle: check outputs at the negedge, apply inputs for the
   // coming posedge, and advance the model by what that edge will do.
   task automatic cyc(input bit a_rdy, input bit r_v, input bit i_rdy,
                      input bit rd_v, input logic [31:0] rd_pc, input logic [1:0] resp);
      bit exp_arv, iv0, out0, rv;
      @(negedge clk);
      exp_arv = !outstanding && !exp_iv;
      iv0     = exp_iv;
      out0    = outstanding;
      rv      = r_v && out0;
      chk("ar_valid", ar_valid, exp_arv);
      if (exp_arv) chk("ar_addr", ar_addr, exp_addr);
      chk("r_ready", r_ready, out0);
      chk("inst_valid", inst_valid, iv0);
      if (iv0) begin
         chk("inst", inst, e_inst);
         chk("inst_pc", inst_pc, e_pc);
         chk("inst_fault", inst_fault, e_flt);
      end
      ar_ready    = a_rdy;
      r_valid     = rv;
      r_data      = out0 ? line(cur_addr) : {$urandom, $urandom};
      r_resp      = resp;
      inst_ready  = i_rdy;
      redir_valid = rd_v;
      redir_pc    = rd_pc;
      if (iv0) begin
         if (rd_v) begin
            exp_iv   = 1'b0;
            exp_addr = rd_pc;
         end else if (i_rdy) begin
            exp_iv   = 1'b0;
            exp_addr = cur_addr + 32'd4;
         end
      end else if (out0) begin
         if (rv) begin
            outstanding = 1'b0;
            if (stale || rd_v) begin
               exp_addr = rd_v ? rd_pc : tgt;
               stale    = 1'b0;
            end else begin
               exp_iv = 1'b1;
               e_inst = word(cur_addr);
               e_pc   = cur_addr;
               e_flt  = (resp != 2'b00);
            end
         end else if (rd_v) begin
            stale = 1'b1;
            tgt   = rd_pc;
         end
      end else begin
         if (rd_v) begin
            stale = 1'b1;
            tgt   = rd_pc;
         end
         if (a_rdy) begin
            outstanding = 1'b1;
            cur_addr    = exp_addr;
         end
      end
   endtask

   task automatic idle_inputs();
      ar_ready = 1'b0; r_valid = 1'b0; inst_ready = 1'b0;
      redir_valid = 1'b0; redir_pc = '0; r_resp = '0;
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_ar_valid", ar_valid, 1'b0);
      chk("rst_r_ready", r_ready, 1'b0);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_inst_fault", inst_fault, 1'b0);
      chk("rst_ar_addr", ar_addr, RESET_PC);
      rstn = 1'b1;
      chk("rel_ar_valid", ar_valid, 1'b0);
   endtask

   // handshake, respond, hold in decode nstall cycles, then accept
   task automatic fetch(input logic [1:0] resp, input int nstall, input logic [31:0] xi,
                        input logic [31:0] xpc, input logic xf);
      cyc(1, 0, 0, 0, 0, 2'b00);
      cyc(0, 1, 0, 0, 0, resp);
      settle();
      chk("f_inst", inst, xi);
      chk("f_inst_pc", inst_pc, xpc);
      chk("f_fault", inst_fault, xf);
      repeat (nstall) cyc(0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 1, 0, 0, 2'b00);
   endtask

   initial begin
      bit          a, rv, ir, rd;
      logic [31:0] rp;
      logic [1:0]  rs;
      do_reset();

      fetch(2'b00, 5, 32'h0010_0093, 32'h3000_0000, 1'b0);
      fetch(2'b00, 0, 32'h0000_0013, 32'h3000_0004, 1'b0);
      fetch(2'b10, 0, word(32'h3000_0008), 32'h3000_0008, 1'b1);
      fetch(2'b00, 0, word(32'h3000_000C), 32'h3000_000C, 1'b0);

      // ar_ready stalled with a redirect mid-stall: request stays, response dropped
      cyc(0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 0, 1, 32'h3000_0100, 2'b00);
      cyc(0, 0, 0, 0, 0, 2'b00);
      settle();
      chk("stall_ar_addr", ar_addr, 32'h3000_0010);
      cyc(0, 0, 0, 0, 0, 2'b00);
      cyc(1, 0, 0, 0, 0, 2'b00);
      cyc(0, 1, 0, 0, 0, 2'b00);
      settle();
      chk("drop_inst_valid", inst_valid, 1'b0);
      chk("redir_ar_addr", ar_addr, 32'h3000_0100);

      // redirect coincident with decode handshake
      cyc(1, 0, 0, 0, 0, 2'b00);
      cyc(0, 1, 0, 0, 0, 2'b00);
      cyc(0, 0, 1, 1, 32'h8000_0000, 2'b00);
      settle();
      chk("co_ar_addr", ar_addr, 32'h8000_0000);
      chk("co_inst_valid", inst_valid, 1'b0);

      // asynchronous reset while a response is pending
      cyc(1, 0, 0, 0, 0, 2'b00);
      settle();
      chk("mid_r_ready", r_ready, 1'b1);
      #1 rstn = 1'b0;
      #1;
      chk("async_ar_valid", ar_valid, 1'b0);
      chk("async_r_ready", r_ready, 1'b0);
      chk("async_ar_addr", ar_addr, RESET_PC);
      do_reset();

      for (int i = 0; i < 4000; i++) begin
         a  = ($urandom_range(0, 9) < 6);
         rv = ($urandom_range(0, 9) < 5);
         ir = ($urandom_range(0, 9) < 6);
         rd = ($urandom_range(0, 99) < 8);
         case ($urandom_range(0, 3))
            0:       rp = 32'hFFFF_FFFC;
            1:       rp = RESET_PC;
            default: rp = $urandom & 32'hFFFF_FFFC;
         endcase
         rs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cyc(a, rv, ir, rd, rp, rs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
